alu_uart_master: RTL and testbench
==================================

Name: alu_uart_master

Overview:
- Host-side command initiator for the UART-ALU link: the other end of the board's byte protocol.
- Accepts one ALU command (operand A, operand B, opcode) over a valid/ready handshake and pushes three bytes into a uart_core TX FIFO.
- Then pops the single result byte from the uart_core RX FIFO and presents it with a valid pulse, or flags a timeout.
- Sits in a loopback or bench top next to a second uart_core, wired to the ALU board's RsRx/RsTx.

Parameters:
- BUS_SIZE, 8, data/byte width of operands, result and UART words.
- OP_BITS, 6, opcode width; zero-extended to BUS_SIZE on the wire.
- TMO_BITS, 20, width of the response timeout counter.
- TMO_CYCLES, 1000000, clk cycles to wait for the result byte before aborting; must be < 2^TMO_BITS.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  block can accept a command (high only in IDLE).
- i_op_a  in  BUS_SIZE  operand A.
- i_op_b  in  BUS_SIZE  operand B.
- i_op_code  in  OP_BITS  ALU opcode.
- o_wr_uart  out  1  single-cycle TX FIFO push.
- o_w_data  out  BUS_SIZE  byte to push.
- i_tx_full  in  1  TX FIFO full.
- o_rd_uart  out  1  single-cycle RX FIFO pop.
- i_r_data  in  BUS_SIZE  RX FIFO head, first-word-fall-through, valid when !i_rx_empty.
- i_rx_empty  in  1  RX FIFO empty.
- o_res_valid  out  1  one-cycle pulse: o_res_data valid.
- o_res_data  out  BUS_SIZE  result byte, held until next result.
- o_timeout  out  1  one-cycle pulse: response timed out.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, any state, including mid-transfer): state = IDLE.
- Reset values: o_cmd_ready = 1, o_wr_uart = 0, o_rd_uart = 0, o_w_data = 0, o_res_valid = 0, o_res_data = 0, o_timeout = 0, o_busy = 0, timeout counter = 0.
- Reset mid-transfer never emits a partial command; bytes already in the TX FIFO are not retracted.
- All outputs are registered.
- States: IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RES, DONE.
- IDLE:
  - o_cmd_ready = 1.
  - On i_cmd_valid, capture i_op_a, i_op_b and i_op_code into internal registers and go to SEND_A.
  - Inputs are not sampled again until the next IDLE.
  - If i_rx_empty = 0 in IDLE, pulse o_rd_uart to drop the stray byte. This takes priority over accepting a command in the same cycle: o_cmd_ready is deasserted that cycle.
- SEND_A / SEND_B / SEND_OP:
  - When i_tx_full = 0, assert o_wr_uart for exactly one cycle with o_w_data set to A, B, or {zeros, op_code} respectively, then advance.
  - While i_tx_full = 1, stall with o_wr_uart = 0 and no timeout counting.
  - A push is issued only in a cycle where i_tx_full was sampled low.
  - Back-to-back pushes are allowed, so 3 bytes take a minimum of 3 cycles.
- WAIT_RES:
  - The timeout counter clears on entry and increments each cycle while i_rx_empty = 1.
  - When i_rx_empty = 0: pulse o_rd_uart, latch i_r_data into o_res_data, go to DONE.
  - When the counter reaches TMO_CYCLES-1 with the RX FIFO still empty: pulse o_timeout, leave o_res_data unchanged, go to IDLE.
  - If data arrives in the same cycle the count expires, data wins: result, no timeout.
- DONE: o_res_valid = 1 for one cycle, then IDLE. A new command is accepted no earlier than the cycle after DONE.
- Latency with empty FIFOs: command accept to the third push = 3 cycles. RX byte visible to o_res_valid = 2 cycles.
- o_wr_uart and o_rd_uart are never asserted in the same cycle except during the IDLE flush; o_wr_uart is never high in IDLE.
- Exactly one result byte is consumed per command; extra bytes are flushed in the following IDLE.

Test Plan:
- Basic: A=0x05, B=0x03, op=0x20, FIFOs empty, model returns 0x08 -> pushes 0x05, 0x03, 0x20 on consecutive cycles; one o_rd_uart; o_res_valid with o_res_data=0x08; o_timeout never asserts.
- Backpressure: i_tx_full held high 10 cycles after the first push -> exactly 3 pushes total, bytes in order, no duplicate or lost byte, no timeout counted during the stall.
- Timeout: TMO_CYCLES=50, no RX byte -> o_timeout pulses once exactly 50 cycles after WAIT_RES entry; o_res_data keeps its previous value; o_cmd_ready returns high.
- Stray flush: two RX bytes queued while IDLE and i_cmd_valid high -> two o_rd_uart pops first, command accepted only after i_rx_empty=1, result of the next command correct.
- Reset mid-send: assert reset after the first push -> all outputs at reset values immediately (async), no further pushes, next command sends a full 3-byte sequence.
- Race: RX byte 0xFF arrives on the final timeout cycle -> o_res_valid with 0xFF, no o_timeout.

Source files
------------

// File: rtl/alu_uart_master_if.sv
// Command, UART FIFO and result signals between alu_uart_master and its environment.
interface alu_uart_master_if #(
  parameter int BUS_SIZE = 8,
  parameter int OP_BITS  = 6
);
  logic                i_cmd_valid;
  logic                o_cmd_ready;
  logic [BUS_SIZE-1:0] i_op_a;
  logic [BUS_SIZE-1:0] i_op_b;
  logic [OP_BITS-1:0]  i_op_code;

  logic                o_wr_uart;
  logic [BUS_SIZE-1:0] o_w_data;
  logic                i_tx_full;

  logic                o_rd_uart;
  logic [BUS_SIZE-1:0] i_r_data;
  logic                i_rx_empty;

  logic                o_res_valid;
  logic [BUS_SIZE-1:0] o_res_data;
  logic                o_timeout;
  logic                o_busy;

  modport master (
    input  i_cmd_valid, i_op_a, i_op_b, i_op_code, i_tx_full, i_r_data, i_rx_empty,
    output o_cmd_ready, o_wr_uart, o_w_data, o_rd_uart, o_res_valid, o_res_data,
           o_timeout, o_busy
  );

  modport slave (
    output i_cmd_valid, i_op_a, i_op_b, i_op_code, i_tx_full, i_r_data, i_rx_empty,
    input  o_cmd_ready, o_wr_uart, o_w_data, o_rd_uart, o_res_valid, o_res_data,
           o_timeout, o_busy
  );
endinterface

// File: rtl/alu_uart_master.sv
// Host-side UART-ALU command initiator: pushes A, B, opcode into the TX FIFO and
// collects the single result byte from the RX FIFO, with a response timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for a command; drops stray RX bytes first
// SEND_A   | push operand A when TX FIFO not full
// SEND_B   | push operand B when TX FIFO not full
// SEND_OP  | push zero-extended opcode when TX FIFO not full
// WAIT_RES | wait for the result byte, counting towards the timeout
// DONE     | raise the result-valid pulse, then return to IDLE
module alu_uart_master #(
  parameter int BUS_SIZE   = 8,
  parameter int OP_BITS    = 6,
  parameter int TMO_BITS   = 20,
  parameter int TMO_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  alu_uart_master_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    SEND_OP,
    WAIT_RES,
    DONE
  } state_t;

  localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(TMO_CYCLES - 1);

  state_t              state_q, state_d;
  logic [BUS_SIZE-1:0] a_q, a_d;
  logic [BUS_SIZE-1:0] b_q, b_d;
  logic [OP_BITS-1:0]  op_q, op_d;
  logic [TMO_BITS-1:0] tmo_q, tmo_d;

  logic                ready_q, ready_d;
  logic                wr_q, wr_d;
  logic [BUS_SIZE-1:0] w_data_q, w_data_d;
  logic                rd_q, rd_d;
  logic                res_valid_q, res_valid_d;
  logic [BUS_SIZE-1:0] res_data_q, res_data_d;
  logic                timeout_q, timeout_d;
  logic                busy_q, busy_d;
  logic                flush;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    tmo_d       = tmo_q;
    wr_d        = 1'b0;
    w_data_d    = w_data_q;
    rd_d        = 1'b0;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    timeout_d   = 1'b0;
    flush       = (state_q == IDLE) && !bus.i_rx_empty;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        // The registered pop lands a cycle late, so skip a cycle after each pop
        // to avoid draining a byte that was never seen.
        if (flush) begin
          rd_d = !rd_q;
        end else if (bus.i_cmd_valid && ready_q) begin
          a_d     = bus.i_op_a;
          b_d     = bus.i_op_b;
          op_d    = bus.i_op_code;
          state_d = SEND_A;
        end
      end
      SEND_A: begin
        if (!bus.i_tx_full) begin
          wr_d     = 1'b1;
          w_data_d = a_q;
          state_d  = SEND_B;
        end
      end
      SEND_B: begin
        if (!bus.i_tx_full) begin
          wr_d     = 1'b1;
          w_data_d = b_q;
          state_d  = SEND_OP;
        end
      end
      SEND_OP: begin
        if (!bus.i_tx_full) begin
          wr_d     = 1'b1;
          w_data_d = BUS_SIZE'(op_q);
          tmo_d    = '0;
          state_d  = WAIT_RES;
        end
      end
      WAIT_RES: begin
        // Data arriving on the last count still wins over the timeout.
        if (!bus.i_rx_empty) begin
          rd_d       = 1'b1;
          res_data_d = bus.i_r_data;
          state_d    = DONE;
        end else if (tmo_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_BITS'(1);
        end
      end
      DONE: begin
        res_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE) && !flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      tmo_q       <= '0;
      ready_q     <= 1'b1;
      wr_q        <= 1'b0;
      w_data_q    <= '0;
      rd_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      tmo_q       <= tmo_d;
      ready_q     <= ready_d;
      wr_q        <= wr_d;
      w_data_q    <= w_data_d;
      rd_q        <= rd_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.o_cmd_ready = ready_q;
  assign bus.o_wr_uart   = wr_q;
  assign bus.o_w_data    = w_data_q;
  assign bus.o_rd_uart   = rd_q;
  assign bus.o_res_valid = res_valid_q;
  assign bus.o_res_data  = res_data_q;
  assign bus.o_timeout   = timeout_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_alu_uart_master.sv
// Bench for alu_uart_master: FIFO/board model around the DUT with TX and result scoreboards.
module tb_alu_uart_master;
  localparam int BUS_SIZE   = 8;
  localparam int OP_BITS    = 6;
  localparam int TMO_BITS   = 20;
  localparam int TMO_CYCLES = 50;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_uart_master_if #(.BUS_SIZE(BUS_SIZE), .OP_BITS(OP_BITS)) bus ();

  alu_uart_master #(
    .BUS_SIZE(BUS_SIZE), .OP_BITS(OP_BITS), .TMO_BITS(TMO_BITS), .TMO_CYCLES(TMO_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_res[$];
  logic [7:0] rx_q[$];
  logic [7:0] last_res = 8'h00;

  int n_push = 0, n_pop = 0, n_res = 0, n_tmo = 0;
  int n_overlap = 0, n_pop_empty = 0;
  bit pop_pending = 0;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  // Board side: RX FIFO model plus TX/result scoreboards, evaluated mid-cycle.
  always @(negedge clk) begin
    logic [7:0] e;
    if (pop_pending) begin
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      else n_pop_empty++;
    end
    pop_pending = 0;
    if (!reset) begin
      if (bus.o_rd_uart) begin
        pop_pending = 1;
        n_pop++;
      end
      if (bus.o_wr_uart && bus.o_rd_uart) n_overlap++;
      if (bus.o_wr_uart) begin
        n_push++;
        checks++;
        if (exp_tx.size() == 0) begin
          failures++;
          $display("FAIL tx_byte unexpected push got=%02h required=none", bus.o_w_data);
        end else begin
          e = exp_tx.pop_front();
          if (bus.o_w_data !== e) begin
            failures++;
            $display("FAIL tx_byte got=%02h required=%02h", bus.o_w_data, e);
          end
        end
      end
      if (bus.o_res_valid) begin
        n_res++;
        checks++;
        if (exp_res.size() == 0) begin
          failures++;
          $display("FAIL res_byte unexpected result got=%02h required=none", bus.o_res_data);
        end else begin
          e = exp_res.pop_front();
          if (bus.o_res_data !== e) begin
            failures++;
            $display("FAIL res_byte got=%02h required=%02h", bus.o_res_data, e);
          end
        end
      end
      if (bus.o_timeout) n_tmo++;
    end
    bus.i_rx_empty = (rx_q.size() == 0);
    bus.i_r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                          output bit ok);
    exp_tx.push_back(a);
    exp_tx.push_back(b);
    exp_tx.push_back({2'b00, op});
    bus.i_op_a      = a;
    bus.i_op_b      = b;
    bus.i_op_code   = op;
    bus.i_cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.o_busy) begin
        ok = 1;
        break;
      end
    end
    bus.i_cmd_valid = 1'b0;
    bus.i_op_a      = 8'($urandom);
    bus.i_op_b      = 8'($urandom);
    bus.i_op_code   = 6'($urandom);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL cmd_accept busy=%0b required=1", bus.o_busy);
    end
  endtask

  task automatic wait_push(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      if (n_push >= target) begin
        ok = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL push_wait pushes=%0d required=%0d", n_push, target);
    end
  endtask

  task automatic wait_res(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 120; i++) begin
      if (n_res >= target) begin
        ok = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL res_wait results=%0d required=%0d", n_res, target);
    end
  endtask

  task automatic finish_cmd(input logic [7:0] r, input int push0, input int res0,
                            input int pop0, input int pops, input int dly);
    bit ok;
    wait_push(push0 + 3, ok);
    repeat (dly) tick();
    exp_res.push_back(r);
    rx_q.push_back(r);
    wait_res(res0 + 1, ok);
    checks++;
    if (bus.o_res_data !== r) begin
      failures++;
      $display("FAIL cmd_res_data got=%02h required=%02h", bus.o_res_data, r);
    end
    checks++;
    if (n_pop != pop0 + pops) begin
      failures++;
      $display("FAIL cmd_pop_count got=%0d required=%0d", n_pop - pop0, pops);
    end
    last_res = r;
  endtask

  task automatic do_cmd(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                        input int dly);
    int push0, res0, pop0;
    bit ok;
    push0 = n_push;
    res0  = n_res;
    pop0  = n_pop;
    send_cmd(a, b, op, ok);
    finish_cmd(alu_model(a, b, op), push0, res0, pop0, 1, dly);
  endtask

  task automatic test_reset();
    logic [21:0] obs, exp_v;
    exp_v = {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    #2 reset = 1'b1;
    #1;
    obs = {bus.o_cmd_ready, bus.o_wr_uart, bus.o_rd_uart, bus.o_w_data, bus.o_res_valid,
           bus.o_res_data, bus.o_timeout, bus.o_busy};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL reset_values got=%06h required=%06h", obs, exp_v);
    end
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus.o_cmd_ready, bus.o_busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release ready_busy=%02b required=10", {bus.o_cmd_ready, bus.o_busy});
    end
  endtask

  task automatic test_basic();
    int push0, res0, pop0, tmo0;
    bit ok;
    push0 = n_push;
    res0  = n_res;
    pop0  = n_pop;
    tmo0  = n_tmo;
    send_cmd(8'h05, 8'h03, 6'h20, ok);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (n_push != push0 + i) begin
        failures++;
        $display("FAIL basic_push_cycle cycle=%0d pushes=%0d required=%0d", i, n_push - push0, i);
      end
    end
    exp_res.push_back(alu_model(8'h05, 8'h03, 6'h20));
    rx_q.push_back(8'h08);
    repeat (2) tick();
    checks++;
    if (n_res != res0) begin
      failures++;
      $display("FAIL basic_res_early results=%0d required=0", n_res - res0);
    end
    tick();
    checks++;
    if (n_res != res0 + 1 || bus.o_res_data !== 8'h08) begin
      failures++;
      $display("FAIL basic_res_latency results=%0d data=%02h required=1,08", n_res - res0,
               bus.o_res_data);
    end
    checks++;
    if (n_pop != pop0 + 1 || n_tmo != tmo0) begin
      failures++;
      $display("FAIL basic_pop_tmo pops=%0d timeouts=%0d required=1,0", n_pop - pop0,
               n_tmo - tmo0);
    end
    checks++;
    if ({bus.o_cmd_ready, bus.o_busy} !== 2'b10) begin
      failures++;
      $display("FAIL basic_idle ready_busy=%02b required=10", {bus.o_cmd_ready, bus.o_busy});
    end
    last_res = 8'h08;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};
    for (int i = 0; i < 5; i++) begin
      do_cmd(8'($urandom), 8'($urandom), ops[i], int'($urandom_range(0, 5)));
    end
    tick();
  endtask

  task automatic test_backpressure();
    int push0, res0, pop0, tmo0;
    bit ok;
    push0 = n_push;
    res0  = n_res;
    pop0  = n_pop;
    tmo0  = n_tmo;
    send_cmd(8'h12, 8'h34, 6'h22, ok);
    wait_push(push0 + 1, ok);
    bus.i_tx_full = 1'b1;
    repeat (10) tick();
    checks++;
    if (n_push != push0 + 1) begin
      failures++;
      $display("FAIL bp_stall pushes=%0d required=1", n_push - push0);
    end
    bus.i_tx_full = 1'b0;
    wait_push(push0 + 3, ok);
    // Respond late: a counter that ran during the stall would expire first.
    repeat (44) tick();
    exp_res.push_back(alu_model(8'h12, 8'h34, 6'h22));
    rx_q.push_back(8'hDE);
    wait_res(res0 + 1, ok);
    repeat (3) tick();
    checks++;
    if (n_push != push0 + 3 || n_tmo != tmo0 || n_pop != pop0 + 1) begin
      failures++;
      $display("FAIL bp_totals pushes=%0d timeouts=%0d pops=%0d required=3,0,1",
               n_push - push0, n_tmo - tmo0, n_pop - pop0);
    end
    last_res = 8'hDE;
  endtask

  task automatic test_timeout();
    int push0, res0, tmo0, tmo_at;
    logic ready_at;
    bit ok;
    push0    = n_push;
    res0     = n_res;
    tmo0     = n_tmo;
    tmo_at   = -1;
    ready_at = 1'b0;
    send_cmd(8'h40, 8'h02, 6'h26, ok);
    wait_push(push0 + 3, ok);
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (n_tmo > tmo0 && tmo_at < 0) begin
        tmo_at   = i;
        ready_at = bus.o_cmd_ready;
      end
    end
    checks++;
    if (tmo_at != TMO_CYCLES) begin
      failures++;
      $display("FAIL tmo_cycle got=%0d required=%0d", tmo_at, TMO_CYCLES);
    end
    checks++;
    if (n_tmo != tmo0 + 1 || n_res != res0) begin
      failures++;
      $display("FAIL tmo_count timeouts=%0d results=%0d required=1,0", n_tmo - tmo0, n_res - res0);
    end
    checks++;
    if (bus.o_res_data !== last_res || ready_at !== 1'b1) begin
      failures++;
      $display("FAIL tmo_hold data=%02h ready=%0b required=%02h,1", bus.o_res_data, ready_at,
               last_res);
    end
  endtask

  task automatic test_race();
    int push0, res0, tmo0, res_at;
    bit ok;
    push0  = n_push;
    res0   = n_res;
    tmo0   = n_tmo;
    res_at = -1;
    send_cmd(8'hFF, 8'h00, 6'h25, ok);
    wait_push(push0 + 3, ok);
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i == TMO_CYCLES - 2) begin
        exp_res.push_back(alu_model(8'hFF, 8'h00, 6'h25));
        rx_q.push_back(8'hFF);
      end
      if (n_res > res0 && res_at < 0) res_at = i;
    end
    checks++;
    if (res_at != TMO_CYCLES + 1 || bus.o_res_data !== 8'hFF) begin
      failures++;
      $display("FAIL race_result cycle=%0d data=%02h required=%0d,ff", res_at, bus.o_res_data,
               TMO_CYCLES + 1);
    end
    checks++;
    if (n_tmo != tmo0) begin
      failures++;
      $display("FAIL race_timeout timeouts=%0d required=0", n_tmo - tmo0);
    end
    last_res = 8'hFF;
  endtask

  task automatic test_stray_flush();
    int push0, res0, pop0;
    bit ok;
    push0 = n_push;
    res0  = n_res;
    pop0  = n_pop;
    rx_q.push_back(8'hAA);
    rx_q.push_back(8'hBB);
    tick();
    send_cmd(8'h0F, 8'hF0, 6'h24, ok);
    checks++;
    if (n_pop != pop0 + 2 || rx_q.size() != 0 || n_push != push0) begin
      failures++;
      $display("FAIL flush_before_accept pops=%0d left=%0d pushes=%0d required=2,0,0",
               n_pop - pop0, rx_q.size(), n_push - push0);
    end
    finish_cmd(alu_model(8'h0F, 8'hF0, 6'h24), push0, res0, pop0, 3, 2);
    tick();
  endtask

  task automatic test_reset_mid_send();
    int push0;
    logic [21:0] obs, exp_v;
    bit ok;
    exp_v = {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    push0 = n_push;
    send_cmd(8'h77, 8'h11, 6'h20, ok);
    wait_push(push0 + 1, ok);
    #1 reset = 1'b1;
    exp_tx.delete();
    #1;
    obs = {bus.o_cmd_ready, bus.o_wr_uart, bus.o_rd_uart, bus.o_w_data, bus.o_res_valid,
           bus.o_res_data, bus.o_timeout, bus.o_busy};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL midreset_values got=%06h required=%06h", obs, exp_v);
    end
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
    checks++;
    if (n_push != push0 + 1) begin
      failures++;
      $display("FAIL midreset_no_push pushes=%0d required=1", n_push - push0);
    end
    do_cmd(8'h21, 8'h09, 6'h22, 1);
  endtask

  task automatic test_invariants();
    checks++;
    if (n_overlap != 0 || n_pop_empty != 0) begin
      failures++;
      $display("FAIL invariants wr_rd_overlap=%0d pop_on_empty=%0d required=0,0", n_overlap,
               n_pop_empty);
    end
    checks++;
    if (exp_tx.size() != 0 || exp_res.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover tx=%0d res=%0d required=0,0", exp_tx.size(),
               exp_res.size());
    end
    checks++;
    if (n_tmo != 1) begin
      failures++;
      $display("FAIL total_timeouts got=%0d required=1", n_tmo);
    end
  endtask

  initial begin
    bus.i_cmd_valid = 1'b0;
    bus.i_op_a      = 8'h00;
    bus.i_op_b      = 8'h00;
    bus.i_op_code   = 6'h00;
    bus.i_tx_full   = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_race();
    test_stray_flush();
    test_reset_mid_send();
    repeat (5) tick();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
